fft_psd_accum: RTL and testbench
================================

FFT_PSD_ACCUM -- requirements
Module: fft_psd_accum

Interface
REQ-001 Parameter IN_W, default 28, SHALL be the width of the signed I/Q samples; it equals the FFT output width.
REQ-002 Parameter FFT_LEN, default 256, SHALL be the number of bins per frame; it is a power of 2 and at least 4.
REQ-003 Parameter AVG_LOG2, default 2, SHALL set the number of frames averaged per output window to 2^AVG_LOG2; it is at least 0.
REQ-004 Localparam PWR_W SHALL equal 2*IN_W, ACC_W SHALL equal PWR_W+AVG_LOG2, and BIN_W SHALL equal $clog2(FFT_LEN).
REQ-005 Port mclk, input, 1 bit: the single clock, rising-edge.
REQ-006 Port i_rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-007 Port i_init, input, 1 bit: synchronous clear, equivalent to reset but taking effect at the next clock edge.
REQ-008 Port i_vld, input, 1 bit: the sample on i_I/i_Q is valid this cycle.
REQ-009 Port i_new_fft, input, 1 bit: qualified by i_vld; marks bin 0 of a natural-order FFT frame.
REQ-010 Port i_I, input, signed IN_W bits: in-phase sample.
REQ-011 Port i_Q, input, signed IN_W bits: quadrature sample.
REQ-012 Port o_vld, output, 1 bit: averaged power bin valid this cycle.
REQ-013 Port o_new_psd, output, 1 bit: qualified by o_vld; marks bin 0 of an output spectrum.
REQ-014 Port o_bin, output, BIN_W bits: bin index of o_pwr.
REQ-015 Port o_pwr, output, unsigned PWR_W bits: averaged I^2+Q^2 for that bin.
REQ-016 Port o_sync_err, output, 1 bit: one-cycle strobe signalling a frame misalignment.

Function
REQ-017 The block SHALL compute pwr = I*I + Q*Q unsigned in PWR_W bits with no overflow; the maximum value 2^(PWR_W-1) occurs at I=Q=-2^(IN_W-1).
REQ-018 The FSM SHALL have two states: SYNC and ACCUM.
REQ-019 SYNC is entered on reset or i_init. In SYNC, samples are ignored until a sample with i_vld and i_new_fft arrives; that sample is bin 0 of frame 0, and the FSM enters ACCUM.
REQ-020 In ACCUM, a bin counter SHALL advance on each i_vld and wrap at FFT_LEN-1 to 0. A frame counter SHALL advance on each wrap and wrap at 2^AVG_LOG2-1 to 0.
REQ-021 Idle cycles with i_vld low SHALL be permitted anywhere; counters and state hold during them.
REQ-022 Accumulation uses an FFT_LEN x ACC_W RAM with a read-modify-write pipeline:
  - in frame 0 the entry is written with pwr (overwrite, no read dependency);
  - in frames 1..2^AVG_LOG2-1 the entry is written with entry+pwr.
REQ-023 In the last frame of a window, the block SHALL output (entry+pwr) >> AVG_LOG2, truncated, on o_pwr, with o_bin equal to the bin index.
REQ-024 o_vld SHALL assert exactly 3 mclk cycles after the accepted i_vld sample; output order SHALL follow input order.
REQ-025 o_vld SHALL be low in all cycles other than those of REQ-023.
REQ-026 o_new_psd SHALL be high only with o_vld and o_bin==0.
REQ-027 If i_vld && i_new_fft arrives while the bin counter is non-zero:
  - o_sync_err pulses 1 cycle, aligned with the would-be output timing (3 cycles later);
  - the partial window is discarded, with no outputs for it;
  - that sample becomes bin 0 of frame 0 of a new window.
REQ-028 If i_new_fft is low when the bin counter is 0 in ACCUM, the block SHALL treat the sample as bin 0 and SHALL NOT flag an error.
REQ-029 Samples in flight in the pipeline when a resync occurs SHALL complete their RAM writes but SHALL NOT produce o_vld.
REQ-030 When AVG_LOG2==0, every frame SHALL be a last frame and o_pwr SHALL equal pwr.

Reset
REQ-031 On i_rst_n low, asynchronously: state=SYNC, counters=0, pipeline valids=0, o_vld=0, o_new_psd=0, o_sync_err=0, o_bin=0, o_pwr=0.
REQ-032 i_init SHALL produce the same values synchronously.
REQ-033 RAM contents are not reset; no sample accepted before a reset or init SHALL ever contribute to an output.
REQ-034 Reset or init mid-window SHALL abandon the window; the next output SHALL come only after 2^AVG_LOG2 full frames following a new i_new_fft.

Structure
REQ-035 Shared package fft_pkg SHALL hold the PWR_W/ACC_W width functions and the FSM state encoding.
REQ-036 The RAM SHALL be a sub-module psd_ram: simple dual-port, 1-cycle registered read, write-first not required.
REQ-037 No same-address RAW hazard SHALL exist, because pipeline depth (3) is less than FFT_LEN.

Verification
Test parameters: IN_W=16, FFT_LEN=8, AVG_LOG2=2.
REQ-038 Constant I=3, Q=4 for 4 frames -> 8 outputs, each o_pwr=25, o_bin 0..7, o_new_psd at bin 0, o_vld 3 cycles after each last-frame input.
REQ-039 Frame f, bin b: I=b, Q=f, 4 frames -> o_pwr[b] = b^2+3 (sum 14/4 truncated).
REQ-040 I=Q=-32768 for 4 frames -> o_pwr=2147483648 on all bins, no wrap.
REQ-041 i_new_fft at bin 5 of frame 2 -> o_sync_err one pulse, no outputs for that window, next outputs 4 full frames after the pulse.
REQ-042 i_rst_n low for 2 cycles during frame 3 -> all outputs 0 immediately; after release, no output until i_new_fft plus 4 frames; values free of pre-reset data.
REQ-043 Scenario REQ-039 with random i_vld gaps (50% idle) -> identical o_pwr/o_bin sequence.

Source files
------------

// File: rtl/fft_pkg.sv
`default_nettype none
// ============================================================================
// fft_pkg : widths and FSM encoding shared by the PSD accumulator blocks
// Rev 1.0
// ============================================================================
package fft_pkg;

    typedef enum logic [0:0] {
        ST_SYNC  = 1'b0,
        ST_ACCUM = 1'b1
    } psd_state_e;

    function automatic int pwr_width(input int in_w);
        return 2 * in_w;
    endfunction

    function automatic int acc_width(input int in_w, input int avg_log2);
        return 2 * in_w + avg_log2;
    endfunction

endpackage
`default_nettype wire

// File: rtl/psd_ram.sv
`default_nettype none
// ============================================================================
// psd_ram : simple dual-port RAM, registered 1-cycle read, no reset
// Rev 1.0
// ============================================================================
module psd_ram #(
    parameter  int DEPTH = 256,
    parameter  int WIDTH = 58,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wdata;
        if (re) rdata_q <= mem_q[raddr];
    end

    assign rdata = rdata_q;

endmodule
`default_nettype wire

// File: rtl/fft_psd_accum.sv
`default_nettype none
// ============================================================================
// fft_psd_accum : averages |X|^2 of 2^AVG_LOG2 consecutive FFT frames per bin
// Rev 1.0
// ============================================================================
module fft_psd_accum
    import fft_pkg::*;
#(
    parameter  int IN_W     = 28,
    parameter  int FFT_LEN  = 256,
    parameter  int AVG_LOG2 = 2,
    localparam int PWR_W    = pwr_width(IN_W),
    localparam int ACC_W    = acc_width(IN_W, AVG_LOG2),
    localparam int BIN_W    = $clog2(FFT_LEN)
) (
    input  logic                   mclk,
    input  logic                   i_rst_n,
    input  logic                   i_init,
    input  logic                   i_vld,
    input  logic                   i_new_fft,
    input  logic signed [IN_W-1:0] i_I,
    input  logic signed [IN_W-1:0] i_Q,
    output logic                   o_vld,
    output logic                   o_new_psd,
    output logic [BIN_W-1:0]       o_bin,
    output logic [PWR_W-1:0]       o_pwr,
    output logic                   o_sync_err
);

    localparam int               FRM_W    = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam logic [BIN_W-1:0] BIN_LAST = BIN_W'(FFT_LEN - 1);
    localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'((1 << AVG_LOG2) - 1);

    psd_state_e       state_q, state_d;
    logic [BIN_W-1:0] bin_q, bin_d;
    logic [FRM_W-1:0] frm_q, frm_d;

    logic             s1_vld_q, s1_vld_d, s1_first_q, s1_first_d;
    logic             s1_last_q, s1_last_d, s1_err_q, s1_err_d;
    logic [BIN_W-1:0] s1_bin_q, s1_bin_d;
    logic [PWR_W-1:0] s1_pwr_q, s1_pwr_d;

    logic             s2_out_q, s2_out_d, s2_err_q, s2_err_d;
    logic [BIN_W-1:0] s2_bin_q, s2_bin_d;
    logic [ACC_W-1:0] s2_sum_q, s2_sum_d;

    logic             o_vld_q, o_vld_d, o_new_psd_q, o_new_psd_d;
    logic             o_sync_err_q, o_sync_err_d;
    logic [BIN_W-1:0] o_bin_q, o_bin_d;
    logic [PWR_W-1:0] o_pwr_q, o_pwr_d;

    logic                    w_accept, w_resync;
    logic [BIN_W-1:0]        w_acc_bin;
    logic [FRM_W-1:0]        w_acc_frm;
    logic signed [PWR_W-1:0] w_i_ext, w_q_ext, w_ii, w_qq;
    logic [PWR_W-1:0]        w_pwr;
    logic [ACC_W-1:0]        w_rd_entry, w_sum;

    // Squares of a signed IN_W value fit in PWR_W-1 bits, so the sum cannot wrap.
    assign w_i_ext = PWR_W'(i_I);
    assign w_q_ext = PWR_W'(i_Q);
    assign w_ii    = w_i_ext * w_i_ext;
    assign w_qq    = w_q_ext * w_q_ext;
    assign w_pwr   = $unsigned(w_ii) + $unsigned(w_qq);

    assign w_sum = s1_first_q ? ACC_W'(s1_pwr_q) : w_rd_entry + ACC_W'(s1_pwr_q);

    psd_ram #(
        .DEPTH (FFT_LEN),
        .WIDTH (ACC_W)
    ) u_ram (
        .clk   (mclk),
        .we    (s1_vld_q),
        .waddr (s1_bin_q),
        .wdata (w_sum),
        .re    (w_accept),
        .raddr (w_acc_bin),
        .rdata (w_rd_entry)
    );

    always_comb begin
        state_d  = state_q;
        bin_d    = bin_q;
        frm_d    = frm_q;
        w_accept = 1'b0;
        w_resync = 1'b0;
        unique case (state_q)
            ST_SYNC: begin
                if (i_vld && i_new_fft) begin
                    w_accept = 1'b1;
                    state_d  = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (i_vld) begin
                    w_accept = 1'b1;
                    w_resync = i_new_fft && (bin_q != '0);
                end
            end
            default: state_d = ST_SYNC;
        endcase

        w_acc_bin = w_resync ? '0 : bin_q;
        w_acc_frm = w_resync ? '0 : frm_q;
        if (w_accept) begin
            if (w_acc_bin == BIN_LAST) begin
                bin_d = '0;
                frm_d = (w_acc_frm == FRM_LAST) ? '0 : w_acc_frm + 1'b1;
            end else begin
                bin_d = w_acc_bin + 1'b1;
                frm_d = w_acc_frm;
            end
        end

        s1_vld_d   = w_accept;
        s1_first_d = (w_acc_frm == '0);
        s1_last_d  = (w_acc_frm == FRM_LAST);
        s1_err_d   = w_resync;
        s1_bin_d   = w_acc_bin;
        s1_pwr_d   = w_pwr;

        // A resync suppresses the outputs of older samples still in flight;
        // their RAM writes proceed and are overwritten by the new frame 0.
        s2_out_d = s1_vld_q && s1_last_q && !w_resync;
        s2_err_d = s1_err_q;
        s2_bin_d = s1_bin_q;
        s2_sum_d = w_sum;

        o_vld_d      = s2_out_q && !w_resync;
        o_new_psd_d  = s2_out_q && !w_resync && (s2_bin_q == '0);
        o_sync_err_d = s2_err_q;
        o_bin_d      = o_vld_d ? s2_bin_q : o_bin_q;
        o_pwr_d      = o_vld_d ? PWR_W'(s2_sum_q >> AVG_LOG2) : o_pwr_q;

        if (i_init) begin
            state_d      = ST_SYNC;
            bin_d        = '0;
            frm_d        = '0;
            s1_vld_d     = 1'b0;
            s1_last_d    = 1'b0;
            s1_err_d     = 1'b0;
            s2_out_d     = 1'b0;
            s2_err_d     = 1'b0;
            o_vld_d      = 1'b0;
            o_new_psd_d  = 1'b0;
            o_sync_err_d = 1'b0;
            o_bin_d      = '0;
            o_pwr_d      = '0;
        end
    end

    always_ff @(posedge mclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= ST_SYNC;
            bin_q        <= '0;
            frm_q        <= '0;
            s1_vld_q     <= 1'b0;
            s1_first_q   <= 1'b0;
            s1_last_q    <= 1'b0;
            s1_err_q     <= 1'b0;
            s1_bin_q     <= '0;
            s1_pwr_q     <= '0;
            s2_out_q     <= 1'b0;
            s2_err_q     <= 1'b0;
            s2_bin_q     <= '0;
            s2_sum_q     <= '0;
            o_vld_q      <= 1'b0;
            o_new_psd_q  <= 1'b0;
            o_sync_err_q <= 1'b0;
            o_bin_q      <= '0;
            o_pwr_q      <= '0;
        end else begin
            state_q      <= state_d;
            bin_q        <= bin_d;
            frm_q        <= frm_d;
            s1_vld_q     <= s1_vld_d;
            s1_first_q   <= s1_first_d;
            s1_last_q    <= s1_last_d;
            s1_err_q     <= s1_err_d;
            s1_bin_q     <= s1_bin_d;
            s1_pwr_q     <= s1_pwr_d;
            s2_out_q     <= s2_out_d;
            s2_err_q     <= s2_err_d;
            s2_bin_q     <= s2_bin_d;
            s2_sum_q     <= s2_sum_d;
            o_vld_q      <= o_vld_d;
            o_new_psd_q  <= o_new_psd_d;
            o_sync_err_q <= o_sync_err_d;
            o_bin_q      <= o_bin_d;
            o_pwr_q      <= o_pwr_d;
        end
    end

    assign o_vld      = o_vld_q;
    assign o_new_psd  = o_new_psd_q;
    assign o_bin      = o_bin_q;
    assign o_pwr      = o_pwr_q;
    assign o_sync_err = o_sync_err_q;

endmodule
`default_nettype wire

// File: tb/tb_fft_psd_accum.sv
`default_nettype none
// ============================================================================
// tb_fft_psd_accum : directed tests for fft_psd_accum (IN_W=16, FFT_LEN=8, AVG_LOG2=2)
// Rev 1.0
// ============================================================================
module tb_fft_psd_accum;

    logic               mclk = 1'b0;
    logic               i_rst_n = 1'b0, i_init = 1'b0, i_vld = 1'b0, i_new_fft = 1'b0;
    logic signed [15:0] i_I = '0, i_Q = '0;
    logic               o_vld, o_new_psd, o_sync_err;
    logic [2:0]         o_bin;
    logic [31:0]        o_pwr;

    int checks = 0, passed = 0, cyc = 0, stray_np = 0;
    int          exp_bin[$], exp_cyc[$], cap_bin[$], cap_cyc[$], err_cyc[$];
    logic [31:0] exp_pwr[$], cap_pwr[$];
    logic        cap_np[$];
    int          ramp_pwr [8] = '{3, 4, 7, 12, 19, 28, 39, 52};

    fft_psd_accum #(.IN_W(16), .FFT_LEN(8), .AVG_LOG2(2)) dut (
        .mclk(mclk), .i_rst_n(i_rst_n), .i_init(i_init), .i_vld(i_vld),
        .i_new_fft(i_new_fft), .i_I(i_I), .i_Q(i_Q), .o_vld(o_vld),
        .o_new_psd(o_new_psd), .o_bin(o_bin), .o_pwr(o_pwr), .o_sync_err(o_sync_err)
    );

    always #5 mclk = ~mclk;
    always @(posedge mclk) cyc <= cyc + 1;

    always @(negedge mclk) begin
        if (o_vld) begin
            cap_bin.push_back(int'(o_bin));
            cap_pwr.push_back(o_pwr);
            cap_np.push_back(o_new_psd);
            cap_cyc.push_back(cyc);
        end
        if (o_new_psd && !o_vld) stray_np++;
        if (o_sync_err) err_cyc.push_back(cyc);
    end

    task automatic idle(input int n);
        repeat (n) begin @(posedge mclk); #1; end
    endtask

    task automatic clear_q();
        exp_bin.delete(); exp_pwr.delete(); exp_cyc.delete();
        cap_bin.delete(); cap_pwr.delete(); cap_np.delete(); cap_cyc.delete(); err_cyc.delete();
    endtask

    task automatic send(input bit nf, input logic signed [15:0] vi, input logic signed [15:0] vq,
                        output int c);
        i_vld = 1'b1; i_new_fft = nf; i_I = vi; i_Q = vq; c = cyc;
        @(posedge mclk); #1;
        i_vld = 1'b0; i_new_fft = 1'b0;
    endtask

    // mode 0: I=3,Q=4  mode 1: I=bin,Q=frame  mode 2: I=Q=-32768
    task automatic run_window(input int mode, input bit nf_all, input bit gaps, output int first_cyc);
        int c;
        logic signed [15:0] vi, vq;
        logic [31:0] ep;
        first_cyc = 0;
        for (int f = 0; f < 4; f++) begin
            for (int b = 0; b < 8; b++) begin
                if (gaps && $urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 2)));
                case (mode)
                    0:       begin vi = 16'sd3; vq = 16'sd4; ep = 32'd25; end
                    1:       begin vi = 16'(b); vq = 16'(f); ep = 32'(ramp_pwr[b]); end
                    default: begin vi = 16'sh8000; vq = 16'sh8000; ep = 32'h8000_0000; end
                endcase
                send(b == 0 && (f == 0 || nf_all), vi, vq, c);
                if (f == 0 && b == 0) first_cyc = c;
                if (f == 3) begin
                    exp_bin.push_back(b); exp_pwr.push_back(ep); exp_cyc.push_back(c + 3);
                end
            end
        end
        idle(6);
    endtask

    task automatic pre_fill(input int n);
        int c;
        for (int k = 0; k < n; k++) send(k % 8 == 0, 16'sd7, 16'sd7, c);
    endtask

    task automatic test_reset();
        #12;
        checks++; if (o_vld !== 1'b0) $display("FAIL reset_o_vld: got %b want 0", o_vld); else passed++;
        checks++; if (o_new_psd !== 1'b0) $display("FAIL reset_o_new_psd: got %b want 0", o_new_psd); else passed++;
        checks++; if (o_sync_err !== 1'b0) $display("FAIL reset_o_sync_err: got %b want 0", o_sync_err); else passed++;
        checks++; if (o_bin !== 3'd0) $display("FAIL reset_o_bin: got %0d want 0", o_bin); else passed++;
        checks++; if (o_pwr !== 32'd0) $display("FAIL reset_o_pwr: got %0d want 0", o_pwr); else passed++;
        @(posedge mclk); #1; i_rst_n = 1'b1;
        idle(2);
    endtask

    task automatic test_constant();
        int fc;
        clear_q();
        run_window(0, 1'b1, 1'b0, fc);
        checks++;
        if (cap_bin.size() !== 8) $display("FAIL const_count: got %0d outputs want 8", cap_bin.size()); else passed++;
        for (int i = 0; i < exp_bin.size() && i < cap_bin.size(); i++) begin
            checks++;
            if (cap_bin[i] !== exp_bin[i] || cap_pwr[i] !== exp_pwr[i] || cap_cyc[i] !== exp_cyc[i] ||
                cap_np[i] !== (exp_bin[i] == 0))
                $display("FAIL const_out[%0d]: got bin=%0d pwr=%0d cyc=%0d np=%b want bin=%0d pwr=%0d cyc=%0d np=%b",
                         i, cap_bin[i], cap_pwr[i], cap_cyc[i], cap_np[i], exp_bin[i], exp_pwr[i], exp_cyc[i], exp_bin[i] == 0);
            else passed++;
        end
    endtask

    task automatic test_ramp(input bit gaps);
        int fc;
        clear_q();
        run_window(1, 1'b0, gaps, fc);
        checks++;
        if (cap_bin.size() !== 8) $display("FAIL ramp_count(gaps=%0d): got %0d want 8", gaps, cap_bin.size()); else passed++;
        for (int i = 0; i < exp_bin.size() && i < cap_bin.size(); i++) begin
            checks++;
            if (cap_bin[i] !== exp_bin[i] || cap_pwr[i] !== exp_pwr[i] || cap_cyc[i] !== exp_cyc[i] ||
                cap_np[i] !== (exp_bin[i] == 0))
                $display("FAIL ramp_out[%0d](gaps=%0d): got bin=%0d pwr=%0d cyc=%0d want bin=%0d pwr=%0d cyc=%0d",
                         i, gaps, cap_bin[i], cap_pwr[i], cap_cyc[i], exp_bin[i], exp_pwr[i], exp_cyc[i]);
            else passed++;
        end
        checks++;
        if (err_cyc.size() !== 0) $display("FAIL ramp_no_err: got %0d sync_err pulses want 0", err_cyc.size()); else passed++;
    endtask

    task automatic test_max();
        int fc;
        clear_q();
        run_window(2, 1'b1, 1'b0, fc);
        checks++;
        if (cap_bin.size() !== 8) $display("FAIL max_count: got %0d want 8", cap_bin.size()); else passed++;
        for (int i = 0; i < exp_bin.size() && i < cap_bin.size(); i++) begin
            checks++;
            if (cap_bin[i] !== exp_bin[i] || cap_pwr[i] !== exp_pwr[i])
                $display("FAIL max_out[%0d]: got bin=%0d pwr=%0d want bin=%0d pwr=%0d",
                         i, cap_bin[i], cap_pwr[i], exp_bin[i], exp_pwr[i]);
            else passed++;
        end
    endtask

    task automatic test_sync_err();
        int fc;
        clear_q();
        pre_fill(21);
        run_window(1, 1'b0, 1'b0, fc);
        checks++;
        if (err_cyc.size() !== 1) $display("FAIL sync_err_count: got %0d pulses want 1", err_cyc.size()); else passed++;
        checks++;
        if (err_cyc.size() > 0 && err_cyc[0] !== fc + 3)
            $display("FAIL sync_err_time: got cyc %0d want %0d", err_cyc[0], fc + 3);
        else passed++;
        checks++;
        if (cap_bin.size() !== 8) $display("FAIL sync_out_count: got %0d want 8", cap_bin.size()); else passed++;
        for (int i = 0; i < exp_bin.size() && i < cap_bin.size(); i++) begin
            checks++;
            if (cap_bin[i] !== exp_bin[i] || cap_pwr[i] !== exp_pwr[i] || cap_cyc[i] !== exp_cyc[i])
                $display("FAIL sync_out[%0d]: got bin=%0d pwr=%0d cyc=%0d want bin=%0d pwr=%0d cyc=%0d",
                         i, cap_bin[i], cap_pwr[i], cap_cyc[i], exp_bin[i], exp_pwr[i], exp_cyc[i]);
            else passed++;
        end
    endtask

    task automatic test_mid_reset();
        int fc, c;
        clear_q();
        pre_fill(29);
        i_rst_n = 1'b0;
        #1;
        checks++;
        if (o_vld !== 1'b0 || o_pwr !== 32'd0 || o_bin !== 3'd0 || o_new_psd !== 1'b0 || o_sync_err !== 1'b0)
            $display("FAIL midreset_outputs: got vld=%b pwr=%0d bin=%0d np=%b err=%b want all 0",
                     o_vld, o_pwr, o_bin, o_new_psd, o_sync_err);
        else passed++;
        idle(2);
        i_rst_n = 1'b1;
        clear_q();
        for (int k = 0; k < 3; k++) send(1'b0, 16'sd9, 16'sd9, c);
        idle(1);
        run_window(1, 1'b1, 1'b0, fc);
        checks++;
        if (cap_bin.size() !== 8) $display("FAIL midreset_count: got %0d want 8", cap_bin.size()); else passed++;
        for (int i = 0; i < exp_bin.size() && i < cap_bin.size(); i++) begin
            checks++;
            if (cap_bin[i] !== exp_bin[i] || cap_pwr[i] !== exp_pwr[i] || cap_cyc[i] !== exp_cyc[i])
                $display("FAIL midreset_out[%0d]: got bin=%0d pwr=%0d cyc=%0d want bin=%0d pwr=%0d cyc=%0d",
                         i, cap_bin[i], cap_pwr[i], cap_cyc[i], exp_bin[i], exp_pwr[i], exp_cyc[i]);
            else passed++;
        end
    endtask

    task automatic test_init();
        int fc;
        clear_q();
        pre_fill(27);
        i_init = 1'b1; i_vld = 1'b1; i_new_fft = 1'b1; i_I = 16'sd9; i_Q = 16'sd9;
        @(posedge mclk); #1;
        i_init = 1'b0; i_vld = 1'b0; i_new_fft = 1'b0;
        checks++;
        if (o_vld !== 1'b0 || o_pwr !== 32'd0 || o_bin !== 3'd0)
            $display("FAIL init_outputs: got vld=%b pwr=%0d bin=%0d want 0 0 0", o_vld, o_pwr, o_bin);
        else passed++;
        idle(2);
        clear_q();
        run_window(0, 1'b1, 1'b0, fc);
        checks++;
        if (cap_bin.size() !== 8) $display("FAIL init_count: got %0d want 8", cap_bin.size()); else passed++;
        for (int i = 0; i < exp_bin.size() && i < cap_bin.size(); i++) begin
            checks++;
            if (cap_bin[i] !== exp_bin[i] || cap_pwr[i] !== exp_pwr[i] || cap_cyc[i] !== exp_cyc[i])
                $display("FAIL init_out[%0d]: got bin=%0d pwr=%0d cyc=%0d want bin=%0d pwr=%0d cyc=%0d",
                         i, cap_bin[i], cap_pwr[i], cap_cyc[i], exp_bin[i], exp_pwr[i], exp_cyc[i]);
            else passed++;
        end
        checks++;
        if (stray_np !== 0) $display("FAIL new_psd_without_vld: got %0d cycles want 0", stray_np); else passed++;
    endtask

    initial begin
        test_reset();
        test_constant();
        test_ramp(1'b0);
        test_max();
        test_ramp(1'b1);
        test_sync_err();
        test_mid_reset();
        test_init();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
`default_nettype wire
